// File: rtl/gg_rowslice_sequencer.sv
// Row-slice sequencer: arms the lattice at each slice payload byte, follows parse
// progress through slice_end/mb_start, and walks a frame of num_rows slices.
//
// state | meaning
// IDLE  | waiting for frame_start
// ARM   | waiting for the word holding the next slice's first payload byte
// RUN   | slice being parsed; counting MBs, watching for slice_end or timeout
module gg_rowslice_sequencer #(
  parameter int WIDTH           = 32,
  parameter int BYTE_WIDTH      = WIDTH / 8,
  parameter int HDR_BYTES       = 5,
  parameter int MAX_SLICE_WORDS = 4096,
  parameter int PTR_W           = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  frame_start,
  input  logic [PTR_W-1:0]      first_byte,
  input  logic [7:0]            num_rows,
  input  logic                  abort,
  output logic [BYTE_WIDTH-1:0] slice_start,
  input  logic [BYTE_WIDTH-1:0] slice_end,
  input  logic [WIDTH-1:0]      mb_start,
  output logic [PTR_W-1:0]      word_ptr,
  output logic [7:0]            row_index,
  output logic [15:0]           mb_coded,
  output logic                  row_done,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_multi_end
);

  localparam int WD_W = $clog2(MAX_SLICE_WORDS + 1);
  localparam int PC_W = $clog2(WIDTH + 1);
  localparam int SE_W = $clog2(BYTE_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  target;
  logic [7:0]        rows_left;
  logic [WD_W-1:0]   wd;
  logic [WD_W-1:0]   wd_inc;
  logic [PTR_W-1:0]  offset;
  logic              hit;
  logic [PC_W-1:0]   mb_pc;
  logic [SE_W-1:0]   se_pc;
  logic [PTR_W-1:0]  end_byte;
  logic [16:0]       mb_sum;
  logic [15:0]       mb_sat;
  logic              load_frame, arm_fire, run_word, end_fire, timeout_fire;
  logic              last_row;

  assign offset   = target - word_ptr;
  assign hit      = offset < PTR_W'(BYTE_WIDTH);
  assign wd_inc   = wd + WD_W'(1);
  assign last_row = (rows_left == 8'd1);
  assign busy     = (state == ARM) || (state == RUN);

  always_comb begin
    mb_pc = '0;
    for (int i = 0; i < WIDTH; i++) mb_pc = mb_pc + PC_W'(mb_start[i]);
    se_pc = '0;
    for (int i = 0; i < BYTE_WIDTH; i++) se_pc = se_pc + SE_W'(slice_end[i]);
    // descending scan so the lowest stream-order byte wins
    end_byte = '0;
    for (int j = BYTE_WIDTH - 1; j >= 0; j--)
      if (slice_end[BYTE_WIDTH-1-j]) end_byte = PTR_W'(j);
  end

  // a fresh slice starts counting from zero in its trigger word
  always_comb begin
    mb_sum = (arm_fire ? 17'd0 : {1'b0, mb_coded}) + 17'(mb_pc);
    mb_sat = mb_sum[16] ? 16'hFFFF : mb_sum[15:0];
  end

  always_comb begin
    state_nxt    = state;
    slice_start  = '0;
    load_frame   = 1'b0;
    arm_fire     = 1'b0;
    run_word     = 1'b0;
    end_fire     = 1'b0;
    timeout_fire = 1'b0;
    if (in_valid) begin
      if (abort) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: if (frame_start) begin
            load_frame = 1'b1;
            state_nxt  = ARM;
          end
          ARM: if (hit) begin
            arm_fire = 1'b1;
            for (int b = 0; b < BYTE_WIDTH; b++)
              slice_start[b] = (offset == PTR_W'(BYTE_WIDTH - 1 - b));
            state_nxt = RUN;
          end
          RUN: begin
            run_word = 1'b1;
            if (|slice_end) begin
              end_fire  = 1'b1;
              state_nxt = last_row ? IDLE : ARM;
            end else if (wd_inc == WD_W'(MAX_SLICE_WORDS)) begin
              timeout_fire = 1'b1;
              state_nxt    = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      word_ptr      <= '0;
      target        <= '0;
      rows_left     <= '0;
      row_index     <= '0;
      mb_coded      <= '0;
      wd            <= '0;
      row_done      <= 1'b0;
      frame_done    <= 1'b0;
      err_timeout   <= 1'b0;
      err_multi_end <= 1'b0;
    end else begin
      state      <= state_nxt;
      row_done   <= end_fire;
      frame_done <= end_fire && last_row;
      if (in_valid) word_ptr <= word_ptr + PTR_W'(BYTE_WIDTH);
      if (load_frame) begin
        target        <= first_byte;
        rows_left     <= num_rows;
        row_index     <= '0;
        err_timeout   <= 1'b0;
        err_multi_end <= 1'b0;
      end
      if (arm_fire) begin
        mb_coded <= mb_sat;
        wd       <= '0;
      end
      if (run_word) begin
        mb_coded <= mb_sat;
        wd       <= wd_inc;
      end
      if (end_fire) begin
        row_index     <= row_index + 8'd1;
        rows_left     <= rows_left - 8'd1;
        target        <= word_ptr + end_byte + PTR_W'(HDR_BYTES + 1);
        err_multi_end <= err_multi_end | (se_pc > SE_W'(1));
      end
      if (timeout_fire) err_timeout <= 1'b1;
    end
  end

endmodule
